pe_weight_load_sequencer: RTL and testbench

Sequences loading of one R x S int8 filter into the weight-stationary PE array. It pulls 32-bit packed weight words from the weight buffer over a valid/ready stream and unpacks them one byte per cycle into a row register. It then issues one row-write strobe per filter row, with the row index, into the PE array. It sits between the weight buffer and the PE array and is started by the accelerator control unit once parameters are valid.

---
 rtl/pe_weight_load_sequencer_pkg.sv | 21 ++
 rtl/pe_weight_load_sequencer_if.sv | 13 +
 rtl/pe_weight_load_sequencer.sv | 152 +++++++++++++++
 tb/tb_pe_weight_load_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_weight_load_sequencer_pkg.sv
// Shared types and helpers for the PE weight-load sequencer.
// Holds the FSM state encoding, the default packing width and the parameter legality check.
package pe_weight_load_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_UNPACK,
        ST_WRITE,
        ST_DONE
    } seq_state_e;

    localparam int WORD_WIDTH_DEFAULT = 32;
    localparam int BYTES_PER_WORD     = WORD_WIDTH_DEFAULT / 8;

    function automatic logic params_legal(input logic [3:0] r, input logic [3:0] s,
                                          input int max_r, input int max_s);
        return (r != 4'd0) && (s != 4'd0) && (int'(r) <= max_r) && (int'(s) <= max_s);
    endfunction

endpackage

// File: rtl/pe_weight_load_sequencer_if.sv
// Valid/ready weight-word stream from the weight buffer (master) to the sequencer (slave).
interface pe_weight_load_sequencer_if
    import pe_weight_load_sequencer_pkg::*;
#(
    parameter int WORD_WIDTH = BYTES_PER_WORD * 8
);
    logic                  valid;
    logic                  ready;
    logic [WORD_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pe_weight_load_sequencer.sv
// Pulls packed int8 weight words, unpacks one byte per cycle into a row register
// and writes one R x S filter into the PE array row by row.
module pe_weight_load_sequencer
    import pe_weight_load_sequencer_pkg::*;
#(
    parameter int PE_ROWS    = 5,
    parameter int PE_COLS    = 5,
    parameter int WORD_WIDTH = BYTES_PER_WORD * 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [3:0]                   param_r_i,
    input  logic [3:0]                   param_s_i,
    pe_weight_load_sequencer_if.slave    w_if,
    output logic                         row_wr_en_o,
    output logic [2:0]                   row_wr_ctrl_o,
    output logic [PE_COLS*8-1:0]         row_data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         param_err_o
);

    localparam int BYTES  = WORD_WIDTH / 8;
    localparam int BIDX_W = $clog2(BYTES + 1);
    localparam int ROW_W  = PE_COLS * 8;

    seq_state_e            state_q, state_d;
    logic [3:0]            r_q, r_d, s_q, s_d, col_q, col_d;
    logic [2:0]            row_q, row_d;
    logic [BIDX_W-1:0]     bidx_q, bidx_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [ROW_W-1:0]      rowreg_q, rowreg_d;
    logic                  perr_q, perr_d;
    logic [7:0]            word_bytes [BYTES];
    logic [7:0]            cur_byte;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
        assign word_bytes[gi] = word_q[gi*8 +: 8];
    end

    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            if (bidx_q == BIDX_W'(i)) cur_byte = word_bytes[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        s_d      = s_q;
        col_d    = col_q;
        row_d    = row_q;
        bidx_d   = bidx_q;
        word_d   = word_q;
        rowreg_d = rowreg_q;
        perr_d   = 1'b0;
        if (abort_i) begin
            state_d  = ST_IDLE;
            col_d    = '0;
            row_d    = '0;
            bidx_d   = '0;
            rowreg_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (params_legal(param_r_i, param_s_i, PE_ROWS, PE_COLS)) begin
                            r_d      = param_r_i;
                            s_d      = param_s_i;
                            col_d    = '0;
                            row_d    = '0;
                            bidx_d   = '0;
                            rowreg_d = '0;
                            state_d  = ST_FETCH;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_if.valid) begin
                        word_d  = w_if.data;
                        bidx_d  = '0;
                        state_d = ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    for (int c = 0; c < PE_COLS; c++) begin
                        if (col_q == 4'(c)) rowreg_d[c*8 +: 8] = cur_byte;
                    end
                    col_d  = col_q + 4'd1;
                    bidx_d = bidx_q + BIDX_W'(1);
                    if (col_q == s_q - 4'd1)               state_d = ST_WRITE;
                    else if (bidx_q == BIDX_W'(BYTES - 1)) state_d = ST_FETCH;
                end
                ST_WRITE: begin
                    col_d    = '0;
                    rowreg_d = '0;
                    if ({1'b0, row_q} == r_q - 4'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + 3'd1;
                        // Rows pack contiguously, so the next row may start mid-word.
                        state_d = (bidx_q != BIDX_W'(BYTES)) ? ST_UNPACK : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            s_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            rowreg_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            s_q      <= s_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            rowreg_q <= rowreg_d;
            perr_q   <= perr_d;
        end
    end

    // Abort suppresses ready in the same cycle so an offered word is never taken and lost.
    assign w_if.ready    = (state_q == ST_FETCH) && !abort_i;
    assign row_wr_en_o   = (state_q == ST_WRITE);
    assign row_wr_ctrl_o = row_q;
    assign row_data_o    = rowreg_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign param_err_o   = perr_q;

endmodule

// File: tb/tb_pe_weight_load_sequencer.sv
// Directed self-checking bench for pe_weight_load_sequencer (5x5 array, 32-bit words).
module tb_pe_weight_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  param_r = 4'd0;
    logic [3:0]  param_s = 4'd0;
    logic        row_wr_en;
    logic [2:0]  row_wr_ctrl;
    logic [39:0] row_data;
    logic        busy, done, param_err;

    int passed = 0;
    int total  = 0;

    pe_weight_load_sequencer_if #(.WORD_WIDTH(32)) w_if ();

    pe_weight_load_sequencer #(.PE_ROWS(5), .PE_COLS(5), .WORD_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .abort_i       (abort),
        .param_r_i     (param_r),
        .param_s_i     (param_s),
        .w_if          (w_if),
        .row_wr_en_o   (row_wr_en),
        .row_wr_ctrl_o (row_wr_ctrl),
        .row_data_o    (row_data),
        .busy_o        (busy),
        .done_o        (done),
        .param_err_o   (param_err)
    );

    always #5 clk = ~clk;

    // Bytes 0x01.. packed little-endian, four per word.
    logic [31:0] words [8];
    logic [2:0]  wr_ctrl_log [8];
    logic [39:0] wr_data_log [8];
    int wr_cnt, hs_cnt, done_cycle, busy_low, widx;

    function automatic logic [39:0] exp_row(input int k, input int s);
        logic [39:0] v;
        v = '0;
        for (int c = 0; c < 5; c++) begin
            if (c < s) v[c*8 +: 8] = 8'(k * s + c + 1);
        end
        return v;
    endfunction

    // Starts a load at a negedge and steps it cycle by cycle; cycle 1 is the first
    // cycle after START is sampled. Ends at the negedge of cycle budget+1 or after DONE.
    task automatic run_load(input int r, input int s, input int stall_mode,
                            input int abort_at, input int restart_at, input int budget);
        wr_cnt = 0; hs_cnt = 0; done_cycle = -1; busy_low = 0; widx = 0;
        param_r = 4'(r);
        param_s = 4'(s);
        start = 1'b1;
        w_if.valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (row_wr_en === 1'b1) begin
                if (wr_cnt < 8) begin
                    wr_ctrl_log[wr_cnt] = row_wr_ctrl;
                    wr_data_log[wr_cnt] = row_data;
                end
                wr_cnt++;
            end
            if (done === 1'b1) done_cycle = cyc;
            else if (busy !== 1'b1) busy_low++;
            if (done_cycle >= 0) break;
            w_if.valid = (stall_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            w_if.data  = (widx < 8) ? words[widx] : 32'hFFFF_FFFF;
            abort = (cyc == abort_at);
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                param_r = 4'd1;
                param_s = 4'd1;
            end
            #1;
            if (w_if.valid && w_if.ready) begin
                hs_cnt++;
                widx++;
            end
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
        end
        w_if.valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if ({w_if.ready, row_wr_en, busy, done, param_err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {w_if.ready, row_wr_en, busy, done, param_err});
        else passed++;
        total++; if (row_wr_ctrl !== 3'd0) $display("FAIL reset_ctrl: got %0d want 0", row_wr_ctrl);
        else passed++;
        total++; if (row_data !== 40'h0) $display("FAIL reset_data: got %h want 0", row_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_full_load();
        run_load(5, 5, 0, -1, -1, 60);
        total++; if (done_cycle !== 38) $display("FAIL full_done_cycle: got %0d want 38", done_cycle);
        else passed++;
        total++; if (wr_cnt !== 5) $display("FAIL full_wr_cnt: got %0d want 5", wr_cnt);
        else passed++;
        total++; if (hs_cnt !== 7) $display("FAIL full_handshakes: got %0d want 7", hs_cnt);
        else passed++;
        total++; if (wr_data_log[0] !== 40'h0504030201) $display("FAIL full_row0: got %h want 0504030201", wr_data_log[0]);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            total++; if (wr_ctrl_log[k] !== 3'(k)) $display("FAIL full_ctrl%0d: got %0d want %0d", k, wr_ctrl_log[k], k);
            else passed++;
            total++; if (wr_data_log[k] !== exp_row(k, 5)) $display("FAIL full_data%0d: got %h want %h", k, wr_data_log[k], exp_row(k, 5));
            else passed++;
        end
        total++; if (busy_low !== 0) $display("FAIL full_busy_low: got %0d want 0", busy_low);
        else passed++;
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) $display("FAIL full_after_done: got %b want 00", {done, busy});
        else passed++;
        $display("test_full_load done_cycle=%0d writes=%0d handshakes=%0d", done_cycle, wr_cnt, hs_cnt);
    endtask

    task automatic test_small();
        run_load(3, 3, 0, -1, -1, 40);
        total++; if (done_cycle !== 16) $display("FAIL small_done_cycle: got %0d want 16", done_cycle);
        else passed++;
        total++; if (wr_cnt !== 3) $display("FAIL small_wr_cnt: got %0d want 3", wr_cnt);
        else passed++;
        total++; if (hs_cnt !== 3) $display("FAIL small_handshakes: got %0d want 3", hs_cnt);
        else passed++;
        total++; if (wr_data_log[0] !== 40'h0000030201) $display("FAIL small_row0: got %h want 0000030201", wr_data_log[0]);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++; if (wr_ctrl_log[k] !== 3'(k)) $display("FAIL small_ctrl%0d: got %0d want %0d", k, wr_ctrl_log[k], k);
            else passed++;
            total++; if (wr_data_log[k] !== exp_row(k, 3)) $display("FAIL small_data%0d: got %h want %h", k, wr_data_log[k], exp_row(k, 3));
            else passed++;
        end
        @(negedge clk);
        $display("test_small done_cycle=%0d writes=%0d", done_cycle, wr_cnt);
    endtask

    task automatic test_stall();
        run_load(5, 5, 1, -1, -1, 100);
        total++; if ((done_cycle > 38) !== 1'b1) $display("FAIL stall_done_cycle: got %0d want >38", done_cycle);
        else passed++;
        total++; if (hs_cnt !== 7) $display("FAIL stall_handshakes: got %0d want 7", hs_cnt);
        else passed++;
        total++; if (busy_low !== 0) $display("FAIL stall_busy_low: got %0d want 0", busy_low);
        else passed++;
        total++; if (wr_cnt !== 5) $display("FAIL stall_wr_cnt: got %0d want 5", wr_cnt);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            total++; if (wr_data_log[k] !== exp_row(k, 5)) $display("FAIL stall_data%0d: got %h want %h", k, wr_data_log[k], exp_row(k, 5));
            else passed++;
        end
        @(negedge clk);
        $display("test_stall done_cycle=%0d handshakes=%0d", done_cycle, hs_cnt);
    endtask

    task automatic test_param_err();
        logic [3:0] rs [2];
        logic [3:0] ss [2];
        rs[0] = 4'd0; ss[0] = 4'd3;
        rs[1] = 4'd3; ss[1] = 4'd6;
        for (int i = 0; i < 2; i++) begin
            param_r = rs[i];
            param_s = ss[i];
            start = 1'b1;
            w_if.valid = 1'b1;
            @(negedge clk);
            start = 1'b0;
            total++; if ({param_err, busy, w_if.ready} !== 3'b100)
                $display("FAIL perr_pulse%0d: got %b want 100", i, {param_err, busy, w_if.ready});
            else passed++;
            @(negedge clk);
            total++; if ({param_err, busy, w_if.ready} !== 3'b000)
                $display("FAIL perr_clear%0d: got %b want 000", i, {param_err, busy, w_if.ready});
            else passed++;
            w_if.valid = 1'b0;
            $display("test_param_err R=%0d S=%0d checked", rs[i], ss[i]);
        end
    endtask

    task automatic test_abort();
        // Cycle 16 is the first UNPACK of row 2 in a 5x5 load.
        run_load(5, 5, 0, 16, -1, 16);
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy);
        else passed++;
        total++; if (wr_cnt !== 2) $display("FAIL abort_wr_cnt: got %0d want 2", wr_cnt);
        else passed++;
        total++; if (hs_cnt !== 3) $display("FAIL abort_handshakes: got %0d want 3", hs_cnt);
        else passed++;
        repeat (3) begin
            total++; if (done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", done);
            else passed++;
            @(negedge clk);
        end
        run_load(5, 5, 0, -1, -1, 60);
        total++; if (done_cycle !== 38) $display("FAIL abort_reload_done: got %0d want 38", done_cycle);
        else passed++;
        total++; if (wr_data_log[0] !== 40'h0504030201) $display("FAIL abort_reload_row0: got %h want 0504030201", wr_data_log[0]);
        else passed++;
        total++; if (wr_data_log[4] !== exp_row(4, 5)) $display("FAIL abort_reload_row4: got %h want %h", wr_data_log[4], exp_row(4, 5));
        else passed++;
        @(negedge clk);
        $display("test_abort reload done_cycle=%0d", done_cycle);
    endtask

    task automatic test_reset_in_write();
        // Stops at the negedge of cycle 8, the WRITE of row 0.
        run_load(5, 5, 0, -1, -1, 7);
        total++; if ({row_wr_en, row_data} !== {1'b1, 40'h0504030201})
            $display("FAIL rstw_in_write: got %b/%h want 1/0504030201", row_wr_en, row_data);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if ({w_if.ready, row_wr_en, busy, done, param_err} !== 5'b0)
            $display("FAIL rstw_flags: got %b want 00000", {w_if.ready, row_wr_en, busy, done, param_err});
        else passed++;
        total++; if ({row_wr_ctrl, row_data} !== 43'h0) $display("FAIL rstw_data: got %0d/%h want 0/0", row_wr_ctrl, row_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset_in_write done");
    endtask

    task automatic test_start_while_busy();
        run_load(5, 5, 0, -1, 10, 60);
        total++; if (done_cycle !== 38) $display("FAIL busy_start_done: got %0d want 38", done_cycle);
        else passed++;
        total++; if (wr_cnt !== 5) $display("FAIL busy_start_wr_cnt: got %0d want 5", wr_cnt);
        else passed++;
        total++; if (wr_data_log[3] !== exp_row(3, 5)) $display("FAIL busy_start_row3: got %h want %h", wr_data_log[3], exp_row(3, 5));
        else passed++;
        total++; if (wr_ctrl_log[4] !== 3'd4) $display("FAIL busy_start_ctrl4: got %0d want 4", wr_ctrl_log[4]);
        else passed++;
        @(negedge clk);
        $display("test_start_while_busy done_cycle=%0d", done_cycle);
    endtask

    initial begin
        words[0] = 32'h04030201; words[1] = 32'h08070605;
        words[2] = 32'h0C0B0A09; words[3] = 32'h100F0E0D;
        words[4] = 32'h14131211; words[5] = 32'h18171615;
        words[6] = 32'h1C1B1A19; words[7] = 32'h201F1E1D;
        w_if.valid = 1'b0;
        w_if.data  = 32'h0;
        @(negedge clk);
        test_reset();
        test_full_load();
        test_small();
        test_stall();
        test_param_err();
        test_abort();
        test_reset_in_write();
        test_start_while_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
